// File: rtl/orb_uart_poller.sv
// Polls CH_NUM RS-485 UART channels: sends REQ_BYTE, captures a PKT_LEN-byte reply per channel into a buffer.
// Latency: 10*CLK_DIV cycles per request frame plus reply time; buffer read port has one cycle latency.
// Backpressure: none; start is ignored while busy, replies are sampled as they arrive on the line.
module orb_uart_poller #(
    parameter int         CH_NUM       = 5,
    parameter int         PKT_LEN      = 18,
    parameter int         CLK_DIV      = 17,
    parameter int         TIMEOUT_BITS = 64,
    parameter logic [7:0] REQ_BYTE     = 8'hA5,
    localparam int        DEPTH        = CH_NUM * PKT_LEN,
    localparam int        AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk80MHz,
    input  logic              rst,
    input  logic              start,
    input  logic [CH_NUM-1:0] UART_RX,
    output logic [CH_NUM-1:0] UART_TX,
    output logic [CH_NUM-1:0] UART_dTX,
    output logic [CH_NUM-1:0] UART_dRX,
    input  logic [AW-1:0]     rd_addr,
    output logic [7:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic [CH_NUM-1:0] tmo_flags,
    output logic [CH_NUM-1:0] ferr_flags
);

    localparam int CW   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int DW   = $clog2(CLK_DIV);
    localparam int TW   = $clog2(TIMEOUT_BITS + 1);
    localparam int IW   = $clog2(PKT_LEN + 1);
    localparam int HALF = CLK_DIV / 2;

    typedef enum logic [2:0] {S_IDLE, S_TX, S_RX_WAIT, S_RX_BYTE, S_NEXT, S_DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     ch_q;
    logic [3:0]        bit_q;
    logic [DW-1:0]     div_q;
    logic [DW-1:0]     tmo_div_q;
    logic [TW-1:0]     tmo_bits_q;
    logic [IW-1:0]     idx_q;
    logic [7:0]        shreg_q;
    logic [CH_NUM-1:0] rx_s1_q, rx_s2_q, rx_s3_q;
    logic [CH_NUM-1:0] tx_q, de_q, tmo_q, ferr_q;
    logic              busy_q, done_q;
    logic [7:0]        rd_data_q;
    logic [7:0]        mem_q [DEPTH];

    logic              rx_cur, rx_fall, sample_now, wr_en;
    logic [AW-1:0]     wr_addr;

    // Line level for request bit b: start bit, REQ_BYTE LSB-first, stop bit.
    function automatic logic tx_bit(input logic [3:0] b);
        if (b == 4'd0) return 1'b0;
        if (b >= 4'd9) return 1'b1;
        return REQ_BYTE[3'(b - 4'd1)];
    endfunction

    // Two-flop synchroniser plus one history stage for falling-edge detection.
    always_ff @(posedge clk80MHz or posedge rst) begin
        if (rst) begin
            rx_s1_q <= '1;
            rx_s2_q <= '1;
            rx_s3_q <= '1;
        end else begin
            rx_s1_q <= UART_RX;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    // Selected-channel receive view and the mid-bit sample strobe.
    always_comb begin
        rx_cur     = rx_s2_q[ch_q];
        rx_fall    = rx_s3_q[ch_q] & ~rx_s2_q[ch_q];
        sample_now = (state_q == S_RX_BYTE) &&
                     (div_q == ((bit_q == 4'd0) ? DW'(HALF - 1) : DW'(CLK_DIV - 1)));
        wr_en      = sample_now && (bit_q == 4'd9);
        wr_addr    = AW'(ch_q) * AW'(PKT_LEN) + AW'(idx_q);
    end

    // Poll sequencer: request, wait for reply start, shift in bytes, advance channel.
    always_ff @(posedge clk80MHz or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            bit_q      <= '0;
            div_q      <= '0;
            tmo_div_q  <= '0;
            tmo_bits_q <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            tx_q       <= '1;
            de_q       <= '0;
            tmo_q      <= '0;
            ferr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_TX;
                        ch_q     <= '0;
                        bit_q    <= '0;
                        div_q    <= '0;
                        busy_q   <= 1'b1;
                        tmo_q    <= '0;
                        ferr_q   <= '0;
                        tx_q     <= '1;
                        tx_q[0]  <= 1'b0;
                        de_q     <= '0;
                        de_q[0]  <= 1'b1;
                    end
                end
                S_TX: begin
                    if (div_q == DW'(CLK_DIV - 1)) begin
                        div_q <= '0;
                        if (bit_q == 4'd9) begin
                            // Stop bit finished: release the driver and open the receive window.
                            tx_q       <= '1;
                            de_q       <= '0;
                            idx_q      <= '0;
                            tmo_div_q  <= '0;
                            tmo_bits_q <= '0;
                            state_q    <= S_RX_WAIT;
                        end else begin
                            bit_q       <= bit_q + 4'd1;
                            tx_q[ch_q]  <= tx_bit(bit_q + 4'd1);
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                S_RX_WAIT: begin
                    if (rx_fall) begin
                        state_q <= S_RX_BYTE;
                        div_q   <= '0;
                        bit_q   <= '0;
                    end else if (tmo_div_q == DW'(CLK_DIV - 1)) begin
                        tmo_div_q <= '0;
                        if (tmo_bits_q == TW'(TIMEOUT_BITS - 1)) begin
                            tmo_q[ch_q] <= 1'b1;
                            state_q     <= S_NEXT;
                        end else begin
                            tmo_bits_q <= tmo_bits_q + TW'(1);
                        end
                    end else begin
                        tmo_div_q <= tmo_div_q + DW'(1);
                    end
                end
                S_RX_BYTE: begin
                    if (sample_now) begin
                        div_q <= '0;
                        if (bit_q == 4'd0) begin
                            // A start bit that is high again at mid-bit was a glitch; keep the timeout running.
                            if (rx_cur) state_q <= S_RX_WAIT;
                            else        bit_q   <= 4'd1;
                        end else if (bit_q < 4'd9) begin
                            shreg_q <= {rx_cur, shreg_q[7:1]};
                            bit_q   <= bit_q + 4'd1;
                        end else begin
                            if (!rx_cur) ferr_q[ch_q] <= 1'b1;
                            if (idx_q == IW'(PKT_LEN - 1)) begin
                                state_q <= S_NEXT;
                            end else begin
                                idx_q      <= idx_q + IW'(1);
                                tmo_div_q  <= '0;
                                tmo_bits_q <= '0;
                                state_q    <= S_RX_WAIT;
                            end
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                S_NEXT: begin
                    if (ch_q == CW'(CH_NUM - 1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        ch_q                <= ch_q + CW'(1);
                        bit_q               <= '0;
                        div_q               <= '0;
                        tx_q                <= '1;
                        tx_q[ch_q + CW'(1)] <= 1'b0;
                        de_q                <= '0;
                        de_q[ch_q + CW'(1)] <= 1'b1;
                        state_q             <= S_TX;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Reply buffer: written on each stop-bit sample, never reset.
    always_ff @(posedge clk80MHz) begin
        if (wr_en) mem_q[wr_addr] <= shreg_q;
    end

    // Registered read port; addresses past the buffer read as zero.
    always_ff @(posedge clk80MHz or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if ({1'b0, rd_addr} < (AW + 1)'(DEPTH)) begin
            rd_data_q <= mem_q[rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign UART_TX    = tx_q;
    assign UART_dTX   = de_q;
    assign UART_dRX   = de_q;
    assign rd_data    = rd_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign tmo_flags  = tmo_q;
    assign ferr_flags = ferr_q;

endmodule

// File: doc/orb_uart_poller.md
# orb_uart_poller

Parametrised request/response poller for CH_NUM RS-485 UART channels in the orbital telemetry frame path. One poll cycle services every channel in turn. For each channel it sends a request byte, switches the line driver to receive, and captures a PKT_LEN-byte reply into an internal buffer, flagging timeouts and framing errors per channel. The frame assembler reads the buffer through a synchronous read port after `done`.

## Interface
- CH_NUM, 5: number of UART channels (1..16)
- PKT_LEN, 18: reply bytes captured per channel (1..64)
- CLK_DIV, 17: clk80MHz cycles per UART bit (≥4)
- TIMEOUT_BITS, 64: bit periods allowed before the first start bit and between consecutive reply bytes
- REQ_BYTE, 8'hA5: request byte sent on each channel
---
- clk80MHz  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that begins a poll cycle; ignored while busy
- UART_RX  in  CH_NUM  serial receive lines, idle high
- UART_TX  out  CH_NUM  serial transmit lines, idle high
- UART_dTX  out  CH_NUM  RS-485 driver enable, active high
- UART_dRX  out  CH_NUM  RS-485 receiver disable, high while transmitting
- rd_addr  in  clog2(CH_NUM*PKT_LEN)  buffer address = ch*PKT_LEN + byte index
- rd_data  out  8  buffer data, one-cycle read latency
- busy  out  1  poll cycle in progress
- done  out  1  one-cycle pulse when the last channel finishes
- tmo_flags  out  CH_NUM  channel i timed out in the last poll
- ferr_flags  out  CH_NUM  channel i had at least one stop bit read as 0 in the last poll

## Operation
- States: IDLE, TX, RX_WAIT, RX_BYTE, NEXT, DONE.
- **IDLE → TX** on `start`:
  - ch ← 0.
  - tmo_flags and ferr_flags cleared.
- **TX**: sends start bit, REQ_BYTE LSB-first, then 1 stop bit on UART_TX[ch].
  - UART_dTX[ch] and UART_dRX[ch] are 1 for the whole 10-bit frame.
  - Both drop to 0 on the cycle after the stop bit ends, and the state moves to RX_WAIT with byte index 0.
- **RX_WAIT**: waits for a falling edge on UART_RX[ch], synchronised through a 2-flop chain.
  - Start bit is re-checked at half a bit period. If it reads 1 (glitch), the state returns to RX_WAIT without resetting the timeout counter.
  - Timeout counter counts bit periods. At TIMEOUT_BITS: tmo_flags[ch] ← 1, go to NEXT.
- **RX_BYTE**: 8 data bits are sampled at mid-bit, LSB-first. The stop bit is sampled at mid-bit.
  - The byte is written to buffer[ch*PKT_LEN+idx] on the stop-bit sample, whatever the stop-bit value.
  - A stop bit of 0 sets ferr_flags[ch].
  - idx+1 == PKT_LEN → NEXT; otherwise → RX_WAIT with the timeout counter reset.
- **NEXT**: ch == CH_NUM-1 → DONE; otherwise ch+1 → TX.
- **DONE**: `done` pulses for 1 cycle, then IDLE.
- Buffer entries that are not received keep their previous contents. Buffer contents are not reset.
- Lines other than UART_TX[ch] and UART_dTX/UART_dRX[ch] stay idle (TX=1, dTX=0, dRX=0). Bytes on non-selected RX lines are ignored.
- Read port is independent of the poll state. rd_addr ≥ CH_NUM*PKT_LEN returns 8'h00.
- `rst` at any point, including mid-frame:
  - State returns to IDLE, which abandons the poll without a `done` pulse.
  - UART_TX = all 1; UART_dTX = UART_dRX = 0; busy = done = 0; tmo_flags = ferr_flags = 0; rd_data = 0.

## Timing
- `start` sampled high at edge N:
  - busy = 1, UART_dTX[0] = UART_dRX[0] = 1 and UART_TX[0] = 0 (start bit) from edge N+1.
- Request frame lasts exactly 10*CLK_DIV cycles.
- Mid-bit sampling falls CLK_DIV/2 (integer division) cycles after the detected falling edge, then every CLK_DIV cycles.
- Synchroniser latency is 2 cycles and is included in edge detection.
- busy falls on the same edge that `done` rises.
- tmo_flags and ferr_flags are stable from the `done` pulse until the next `start`.
- Silent channel costs 10*CLK_DIV + TIMEOUT_BITS*CLK_DIV cycles, ±2.
- `start` coinciding with `done`, or arriving while busy, is ignored.

## Test plan
- Reset: assert rst mid-simulation → UART_TX=5'b11111, UART_dTX=UART_dRX=0, busy=0, done=0, flags=0, regardless of clock.
- Full poll with defaults: each channel replies 30 bit times after UART_dRX falls, with bytes {ch, 10, 20, …, 170} → done pulses once, tmo_flags=0, ferr_flags=0. rd_addr=2*18+5 → rd_data=50 one cycle later. rd_addr=4*18+0 → 4.
- Channel 2 silent → tmo_flags=5'b00100. Channel 3 request starts 64 bit periods (±2 cycles) after channel 2's receive window opens. Buffer for channel 2 is unchanged.
- Channel 0 sends only 7 bytes → tmo_flags[0]=1, bytes 0..6 stored, byte 7 keeps its prior value. Channels 1..4 are unaffected.
- Channel 1 byte 4 sent with stop bit 0 → ferr_flags=5'b00010, byte 4 still stored, byte 5 received normally.
- Glitch and restart:
  - A 1-cycle low pulse on UART_RX[0] in RX_WAIT produces no byte.
  - Second `start` while busy is ignored (only one done).
  - rst during channel 3 RX_BYTE → IDLE within 0 cycles; a new `start` then polls from channel 0.
